// File: rtl/lc3b_types.sv
// Shared LC-3b type package.
// Purpose: common word/line types for the cache hierarchy plus the state
// type and address-offset width used by the physical-memory responder.
// Ports: none (package only).
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  // Bytes within a 128-bit line are addressed by the low 4 address bits.
  localparam int LINE_OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_array.sv
// Line storage for the physical-memory responder.
// Purpose: DEPTH x 128-bit array with one synchronous write port and one
// combinational read port. Contents are never reset.
// Ports:
//   clk    - clock, rising edge
//   we     - write enable
//   waddr  - write line index
//   wdata  - write line
//   raddr  - read line index
//   rdata  - read line (combinational from raddr)
module pmem_line_array
  import lc3b_types::*;
#(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  lc3b_line                 wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output lc3b_line                 rdata
);

  lc3b_line mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pmem_responder.sv
// Physical-memory responder for the L2 cache pmem port.
// Purpose: answers line reads/writes with a single-cycle pmem_resp after a
// programmable latency, backed by an internal line array.
// Ports:
//   clk, rst_n    - clock (rising edge), asynchronous active-low reset
//   pmem_read     - read strobe, held until pmem_resp
//   pmem_write    - write strobe, held until pmem_resp
//   pmem_address  - byte address; line index taken above the line offset
//   pmem_wdata    - write line
//   pmem_resp     - one-cycle completion pulse
//   pmem_rdata    - read line, valid in the resp cycle of a read, then held
//   protocol_err  - sticky protocol-violation flag, cleared only by reset
module pmem_responder
  import lc3b_types::*;
#(
  parameter int DEPTH         = 64,
  parameter int READ_LATENCY  = 10,
  parameter int WRITE_LATENCY = 10
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     pmem_read,
  input  logic     pmem_write,
  input  lc3b_word pmem_address,
  input  lc3b_line pmem_wdata,
  output logic     pmem_resp,
  output lc3b_line pmem_rdata,
  output logic     protocol_err
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [7:0] RD_INIT = 8'(READ_LATENCY - 1);
  localparam logic [7:0] WR_INIT = 8'(WRITE_LATENCY - 1);

  pmem_state_t      state;
  logic [7:0]       count;
  logic [IDX_W-1:0] idx;
  lc3b_line         wdata_q;
  logic             op_write;

  logic [IDX_W-1:0] req_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [7:0]       init_count;
  logic             strobe_held;
  logic             array_we;
  lc3b_line         array_rdata;
  logic             addr_unused;

  assign req_idx     = pmem_address[LINE_OFFSET_BITS +: IDX_W];
  assign addr_unused = ^{pmem_address[15:LINE_OFFSET_BITS+IDX_W],
                         pmem_address[LINE_OFFSET_BITS-1:0]};

  // With latency 1 the read data is loaded on the capture edge itself, so
  // the array is addressed straight from the bus while idle.
  assign rd_idx = (state == IDLE) ? req_idx : idx;

  // A write wins when both strobes are high.
  assign init_count = pmem_write ? WR_INIT : RD_INIT;

  // Only the strobe of the captured op keeps a request alive.
  assign strobe_held = op_write ? pmem_write : pmem_read;

  // Writes commit on the edge that ends the response cycle.
  assign array_we = (state == RESP) && op_write;

  pmem_line_array #(
    .DEPTH (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (array_we),
    .waddr (idx),
    .wdata (wdata_q),
    .raddr (rd_idx),
    .rdata (array_rdata)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      count        <= 8'd0;
      idx          <= '0;
      wdata_q      <= '0;
      op_write     <= 1'b0;
      pmem_resp    <= 1'b0;
      pmem_rdata   <= '0;
      protocol_err <= 1'b0;
    end else begin
      pmem_resp <= 1'b0;
      case (state)
        IDLE: begin
          if (pmem_read || pmem_write) begin
            idx      <= req_idx;
            wdata_q  <= pmem_wdata;
            op_write <= pmem_write;
            count    <= init_count;
            if (pmem_read && pmem_write) begin
              protocol_err <= 1'b1;
            end
            if (init_count == 8'd0) begin
              state     <= RESP;
              pmem_resp <= 1'b1;
              if (!pmem_write) begin
                pmem_rdata <= array_rdata;
              end
            end else begin
              state <= BUSY;
            end
          end
        end
        BUSY: begin
          // An abandoned request leaves without responding or writing.
          if (!strobe_held) begin
            state        <= IDLE;
            count        <= 8'd0;
            protocol_err <= 1'b1;
          end else if (count == 8'd1) begin
            count     <= 8'd0;
            state     <= RESP;
            pmem_resp <= 1'b1;
            if (!op_write) begin
              pmem_rdata <= array_rdata;
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder.
// Purpose: drives two instances (slow latencies and single-cycle latencies)
// and compares responses against a line-array reference model.
// Ports: none.
module tb_pmem_responder;
  import lc3b_types::*;

  localparam int A_RLAT = 10;
  localparam int A_WLAT = 7;
  localparam int DEPTH  = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic     a_read = 1'b0, a_write = 1'b0;
  lc3b_word a_address = '0;
  lc3b_line a_wdata = '0;
  logic     a_resp, a_err;
  lc3b_line a_rdata;

  logic     b_read = 1'b0, b_write = 1'b0;
  lc3b_word b_address = '0;
  lc3b_line b_wdata = '0;
  logic     b_resp, b_err;
  lc3b_line b_rdata;

  int errors = 0;
  int checks = 0;

  lc3b_line model_mem [DEPTH];
  lc3b_line exp_rdata = '0;
  logic     exp_err = 1'b0;

  always #5 clk = ~clk;

  pmem_responder #(
    .DEPTH         (DEPTH),
    .READ_LATENCY  (A_RLAT),
    .WRITE_LATENCY (A_WLAT)
  ) dut_a (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (a_read),
    .pmem_write   (a_write),
    .pmem_address (a_address),
    .pmem_wdata   (a_wdata),
    .pmem_resp    (a_resp),
    .pmem_rdata   (a_rdata),
    .protocol_err (a_err)
  );

  pmem_responder #(
    .DEPTH         (DEPTH),
    .READ_LATENCY  (1),
    .WRITE_LATENCY (1)
  ) dut_b (
    .clk          (clk),
    .rst_n        (rst_n),
    .pmem_read    (b_read),
    .pmem_write   (b_write),
    .pmem_address (b_address),
    .pmem_wdata   (b_wdata),
    .pmem_resp    (b_resp),
    .pmem_rdata   (b_rdata),
    .protocol_err (b_err)
  );

  // Line index as the byte address divided by the line size, wrapped by depth.
  function automatic int line_of(input lc3b_word a);
    return (int'(a) / 16) % DEPTH;
  endfunction

  function automatic lc3b_line rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One complete request on instance A, started one delta after an edge.
  task automatic do_op(input bit wr, input bit rd, input lc3b_word addr,
                       input lc3b_line data, input string tag);
    int lat;
    int got;
    lat = wr ? A_WLAT : A_RLAT;
    got = 0;
    a_write = wr;
    a_read = rd;
    a_address = addr;
    a_wdata = data;
    for (int k = 1; k <= lat + 4; k++) begin
      @(posedge clk);
      #1;
      if (k == 1) begin
        a_address = lc3b_word'($urandom);
        a_wdata = rand_line();
      end
      if (a_resp) begin
        got = k;
        break;
      end
    end
    if (wr) begin
      model_mem[line_of(addr)] = data;
    end else begin
      exp_rdata = model_mem[line_of(addr)];
    end
    if (wr && rd) begin
      exp_err = 1'b1;
    end
    checks++;
    if (got !== lat) begin
      errors++;
      $display("[TB] FAIL %s latency: got %0d expected %0d", tag, got, lat);
    end
    checks++;
    if (a_rdata !== exp_rdata) begin
      errors++;
      $display("[TB] FAIL %s rdata: got %h expected %h", tag, a_rdata, exp_rdata);
    end
    checks++;
    if (a_err !== exp_err) begin
      errors++;
      $display("[TB] FAIL %s protocol_err: got %b expected %b", tag, a_err, exp_err);
    end
    @(posedge clk);
    #1;
    a_write = 1'b0;
    a_read = 1'b0;
    checks++;
    if (a_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL %s resp_width: got %b expected 0", tag, a_resp);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({a_resp, a_err, b_resp, b_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b expected 0000", {a_resp, a_err, b_resp, b_err});
    end
    checks++;
    if (a_rdata !== '0 || b_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL reset_rdata: got %h/%h expected 0", a_rdata, b_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_read_fresh();
    do_op(1'b0, 1'b1, 16'h0040, '0, "fresh_read");
  endtask

  task automatic test_write_read();
    do_op(1'b1, 1'b0, 16'h0120, 128'h0123456789ABCDEF0123456789ABCDEF, "wr_0120");
    do_op(1'b0, 1'b1, 16'h012F, '0, "rd_012F");
    do_op(1'b0, 1'b1, 16'h0130, '0, "rd_0130");
  endtask

  task automatic test_random();
    lc3b_word addr;
    bit wr;
    for (int i = 0; i < 24; i++) begin
      addr = lc3b_word'($urandom);
      addr[9:4] = 6'($urandom_range(0, 7));
      wr = 1'($urandom_range(0, 1));
      do_op(wr, !wr, addr, rand_line(), wr ? "rand_wr" : "rand_rd");
    end
  endtask

  task automatic test_back_to_back();
    lc3b_line d;
    d = rand_line();
    b_write = 1'b1;
    b_address = 16'h0450;
    b_wdata = d;
    @(posedge clk);
    #1;
    checks++;
    if (b_resp !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_write_resp: got %b expected 1", b_resp);
    end
    @(posedge clk);
    #1;
    b_write = 1'b0;
    b_read = 1'b1;
    b_address = 16'h045A;
    checks++;
    if (b_resp !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_idle_gap: got %b expected 0", b_resp);
    end
    @(posedge clk);
    #1;
    checks++;
    if (b_resp !== 1'b1 || b_rdata !== d) begin
      errors++;
      $display("[TB] FAIL b2b_read: got resp=%b data=%h expected resp=1 data=%h", b_resp, b_rdata, d);
    end
    @(posedge clk);
    #1;
    b_read = 1'b0;
    checks++;
    if (b_resp !== 1'b0 || b_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_end: got resp=%b err=%b expected 0/0", b_resp, b_err);
    end
  endtask

  task automatic test_both_strobes();
    do_op(1'b1, 1'b1, 16'h0200, rand_line(), "both_strobes");
    do_op(1'b0, 1'b1, 16'h0208, '0, "both_readback");
  endtask

  task automatic test_abort();
    bit seen;
    seen = 1'b0;
    a_read = 1'b1;
    a_address = 16'h0250;
    repeat (4) @(posedge clk);
    #1;
    a_read = 1'b0;
    for (int k = 0; k < A_RLAT + 3; k++) begin
      @(posedge clk);
      #1;
      if (a_resp) seen = 1'b1;
    end
    exp_err = 1'b1;
    checks++;
    if (seen !== 1'b0 || a_err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort: got resp_seen=%b err=%b expected 0/1", seen, a_err);
    end
    do_op(1'b0, 1'b1, 16'h0120, '0, "after_abort");
  endtask

  task automatic test_reset_mid_write();
    do_op(1'b1, 1'b0, 16'h0300, rand_line(), "pre_0300");
    do_op(1'b0, 1'b1, 16'h0120, '0, "load_rdata");
    a_write = 1'b1;
    a_address = 16'h0300;
    a_wdata = rand_line();
    repeat (5) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (a_resp !== 1'b0 || a_err !== 1'b0 || a_rdata !== '0) begin
      errors++;
      $display("[TB] FAIL async_reset: got resp=%b err=%b rdata=%h expected 0", a_resp, a_err, a_rdata);
    end
    a_write = 1'b0;
    exp_err = 1'b0;
    exp_rdata = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    do_op(1'b0, 1'b1, 16'h0300, '0, "rd_0300");
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    $display("[TB] starting pmem_responder bench");
    test_reset();
    test_read_fresh();
    test_write_read();
    test_random();
    test_back_to_back();
    test_both_strobes();
    test_abort();
    test_reset_mid_write();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
